sync_cs_decoder: RTL and testbench



---
 rtl/sync_cs_decoder_if.sv | 23 ++
 rtl/sync_cs_decoder.sv | 151 +++++++++++++++
 tb/tb_sync_cs_decoder.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_cs_decoder_if.sv
// Request and chip-select bundle between the bus sequencer (master) and sync_cs_decoder (slave).
interface sync_cs_decoder_if #(
  parameter int unsigned SEL_W = 3
);
  localparam int unsigned N = 2 ** SEL_W;

  logic             req_valid;
  logic [SEL_W-1:0] req_sel;
  logic             req_ready;
  logic [N-1:0]     y;
  logic             active;
  logic [SEL_W-1:0] cur_sel;

  modport master (
    output req_valid, req_sel,
    input  req_ready, y, active, cur_sel
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, y, active, cur_sel
  );
endinterface

// File: rtl/sync_cs_decoder.sv
// Registered SEL_W-to-2**SEL_W active-low chip-select decoder with break-before-make dead time.
// Optional macro SYNC_CS_DECODER_MIN_ACTIVE_EN adds a minimum-active hold before retargeting.
module sync_cs_decoder #(
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned DEAD_CYCLES = 1,
  parameter int unsigned MIN_ACTIVE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             g1,
  input  logic             ng2a,
  input  logic             ng2b,
  sync_cs_decoder_if.slave bus
);
  localparam int unsigned N = 2 ** SEL_W;

  typedef enum logic [1:0] {StIdle, StDead, StActive} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [N-1:0]     y_q, y_d;
  logic             active_q, active_d;
  logic             en, ready, accept;
  logic             start, enter_active;
`ifdef SYNC_CS_DECODER_MIN_ACTIVE_EN
  logic [3:0]       hold_q, hold_d;
`endif

  if (DEAD_CYCLES > 15) begin : g_dead_range
    $error("DEAD_CYCLES must be in 0..15");
  end
  if (MIN_ACTIVE < 1 || MIN_ACTIVE > 15) begin : g_min_range
    $error("MIN_ACTIVE must be in 1..15");
  end

  assign en     = g1 & ~ng2a & ~ng2b;
  assign accept = bus.req_valid & ready & en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cur_sel_q <= '0;
      y_q       <= '1;
      active_q  <= 1'b0;
`ifdef SYNC_CS_DECODER_MIN_ACTIVE_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
      y_q       <= y_d;
      active_q  <= active_d;
`ifdef SYNC_CS_DECODER_MIN_ACTIVE_EN
      hold_q    <= hold_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_sel_d    = cur_sel_q;
    y_d          = y_q;
    active_d     = active_q;
    start        = 1'b0;
    enter_active = 1'b0;
`ifdef SYNC_CS_DECODER_MIN_ACTIVE_EN
    hold_d       = (hold_q != 4'd0) ? hold_q - 4'd1 : 4'd0;
`endif

    unique case (state_q)
      StIdle: begin
        start = accept;
      end
      StDead: begin
        if (!en) begin
          state_d  = StIdle;
          cnt_d    = '0;
          y_d      = '1;
          active_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d         = StActive;
            y_d             = '1;
            y_d[cur_sel_q]  = 1'b0;
            active_d        = 1'b1;
            enter_active    = 1'b1;
          end
        end
      end
      StActive: begin
        // Enable loss wins over any request; same-index requests are absorbed silently.
        if (!en) begin
          state_d  = StIdle;
          y_d      = '1;
          active_d = 1'b0;
        end else if (accept && (bus.req_sel != cur_sel_q)) begin
          start = 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        y_d      = '1;
        active_d = 1'b0;
      end
    endcase

    if (start) begin
      cur_sel_d = bus.req_sel;
      y_d       = '1;
      active_d  = 1'b0;
      if (DEAD_CYCLES == 0) begin
        // Old select released and new one driven in the same edge: never two-cold.
        state_d           = StActive;
        y_d[bus.req_sel]  = 1'b0;
        active_d          = 1'b1;
        enter_active      = 1'b1;
      end else begin
        state_d = StDead;
        cnt_d   = 4'(DEAD_CYCLES);
      end
    end

`ifdef SYNC_CS_DECODER_MIN_ACTIVE_EN
    if (enter_active) begin
      hold_d = 4'(MIN_ACTIVE);
    end else if (state_d == StIdle) begin
      hold_d = '0;
    end
`endif
  end

  always_comb begin
    ready = (state_q != StDead);
`ifdef SYNC_CS_DECODER_MIN_ACTIVE_EN
    if ((state_q == StActive) && (hold_q != 4'd0)) begin
      ready = 1'b0;
    end
`endif
  end

  assign bus.req_ready = ready;
  assign bus.y         = y_q;
  assign bus.active    = active_q;
  assign bus.cur_sel   = cur_sel_q;

endmodule

// File: tb/tb_sync_cs_decoder.sv
// Self-checking bench: two decoder instances (SEL_W=3/DEAD=1 and SEL_W=4/DEAD=0) vs a timeline model.
module tb_sync_cs_decoder;
  localparam int unsigned SelA   = 3;
  localparam int unsigned DeadA  = 1;
  localparam int unsigned SelB   = 4;
  localparam int unsigned DeadB  = 0;
  localparam int unsigned MinAct = 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] g1;
  logic [1:0] ng2a;
  logic [1:0] ng2b;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: a select is "on" from cycle m_start until enable loss or reset.
  int unsigned cyc;
  bit          m_on    [2];
  int unsigned m_sel   [2];
  int unsigned m_start [2];

  sync_cs_decoder_if #(.SEL_W(SelA)) bus_a ();
  sync_cs_decoder_if #(.SEL_W(SelB)) bus_b ();

  sync_cs_decoder #(.SEL_W(SelA), .DEAD_CYCLES(DeadA), .MIN_ACTIVE(MinAct)) dut_a (
    .clk(clk), .rst_n(rst_n), .g1(g1[0]), .ng2a(ng2a[0]), .ng2b(ng2b[0]), .bus(bus_a)
  );

  sync_cs_decoder #(.SEL_W(SelB), .DEAD_CYCLES(DeadB), .MIN_ACTIVE(MinAct)) dut_b (
    .clk(clk), .rst_n(rst_n), .g1(g1[1]), .ng2a(ng2a[1]), .ng2b(ng2b[1]), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1);
  end

  function automatic int unsigned dead_of(int i);
    return (i == 0) ? DeadA : DeadB;
  endfunction

  function automatic bit m_live(int i);
    return m_on[i] && (cyc >= m_start[i]);
  endfunction

  function automatic bit m_ready(int i);
    if (m_on[i] && (cyc < m_start[i])) return 1'b0;
`ifdef SYNC_CS_DECODER_MIN_ACTIVE_EN
    if (m_live(i) && (cyc - m_start[i] < MinAct)) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [15:0] m_y(int i);
    logic [15:0] v;
    v = '1;
    if (m_live(i)) v[m_sel[i]] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    cyc     = 0;
    m_on    = '{1'b0, 1'b0};
    m_sel   = '{0, 0};
    m_start = '{0, 0};
  endtask

  // One clock: capture inputs, advance model at the rising edge, return at the falling edge.
  task automatic tick();
    bit          en [2];
    bit          rv [2];
    int unsigned rs [2];
    en[0] = g1[0] & ~ng2a[0] & ~ng2b[0];
    en[1] = g1[1] & ~ng2a[1] & ~ng2b[1];
    rv[0] = bus_a.req_valid;
    rv[1] = bus_b.req_valid;
    rs[0] = int'(bus_a.req_sel);
    rs[1] = int'(bus_b.req_sel);
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (!en[i]) begin
          m_on[i] = 1'b0;
        end else if (rv[i] && m_ready(i) && (!m_on[i] || rs[i] != m_sel[i])) begin
          m_on[i]    = 1'b1;
          m_sel[i]   = rs[i];
          m_start[i] = cyc + 1 + dead_of(i);
        end
      end
      cyc++;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_chk++;
      if ($countones(~bus_a.y) > 1 || $countones(~bus_b.y) > 1) begin
        n_fail++;
        $display("FAIL one_cold: y_a=%h y_b=%h, required at most one bit low", bus_a.y, bus_b.y);
      end
    end
  end

  task automatic test_reset();
    apply_reset();
    repeat (2) tick();
    n_chk += 5;
    if (bus_a.y !== 8'hFF) begin
      n_fail++; $display("FAIL reset_y_a: got %h, expected ff", bus_a.y);
    end
    if (bus_a.active !== 1'b0) begin
      n_fail++; $display("FAIL reset_active: got %b, expected 0", bus_a.active);
    end
    if (bus_a.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b, expected 1", bus_a.req_ready);
    end
    if (bus_a.cur_sel !== 3'd0) begin
      n_fail++; $display("FAIL reset_cur_sel: got %0d, expected 0", bus_a.cur_sel);
    end
    if (bus_b.y !== 16'hFFFF) begin
      n_fail++; $display("FAIL reset_y_b: got %h, expected ffff", bus_b.y);
    end
  endtask

  task automatic test_basic();
    bus_a.req_valid = 1'b1;
    bus_a.req_sel   = 3'd3;
    tick();
    bus_a.req_valid = 1'b0;
    n_chk += 4;
    if (bus_a.y !== 8'hFF) begin
      n_fail++; $display("FAIL basic_dead_y: got %h, expected ff", bus_a.y);
    end
    if (bus_a.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_dead_ready: got %b, expected 0", bus_a.req_ready);
    end
    tick();
    if (bus_a.y !== 8'hF7) begin
      n_fail++; $display("FAIL basic_y: got %h, expected f7", bus_a.y);
    end
    if (bus_a.active !== 1'b1) begin
      n_fail++; $display("FAIL basic_active: got %b, expected 1", bus_a.active);
    end
  endtask

  task automatic test_retarget();
    repeat (3) tick();
    bus_a.req_valid = 1'b1;
    bus_a.req_sel   = 3'd6;
    tick();
    bus_a.req_valid = 1'b0;
    n_chk += 6;
    if (bus_a.y !== 8'hFF) begin
      n_fail++; $display("FAIL retarget_break_y: got %h, expected ff", bus_a.y);
    end
    if (bus_a.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL retarget_dead_ready: got %b, expected 0", bus_a.req_ready);
    end
    if (bus_a.cur_sel !== 3'd6) begin
      n_fail++; $display("FAIL retarget_cur_sel: got %0d, expected 6", bus_a.cur_sel);
    end
    tick();
    if (bus_a.y !== 8'hBF) begin
      n_fail++; $display("FAIL retarget_make_y: got %h, expected bf", bus_a.y);
    end
    repeat (3) tick();
    bus_a.req_valid = 1'b1;
    tick();
    bus_a.req_valid = 1'b0;
    if (bus_a.y !== 8'hBF) begin
      n_fail++; $display("FAIL same_index_y: got %h, expected bf", bus_a.y);
    end
    tick();
    if (bus_a.y !== 8'hBF) begin
      n_fail++; $display("FAIL same_index_hold_y: got %h, expected bf", bus_a.y);
    end
  endtask

  task automatic test_en_drop_dead();
    bus_a.req_valid = 1'b1;
    bus_a.req_sel   = 3'd5;
    tick();
    bus_a.req_valid = 1'b0;
    ng2a[0]         = 1'b1;
    tick();
    n_chk += 2;
    if (bus_a.active !== 1'b0) begin
      n_fail++; $display("FAIL drop_active: got %b, expected 0", bus_a.active);
    end
    if (bus_a.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL drop_idle_ready: got %b, expected 1", bus_a.req_ready);
    end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (bus_a.y !== 8'hFF) begin
        n_fail++; $display("FAIL drop_y cycle %0d: got %h, expected ff", k, bus_a.y);
      end
      tick();
    end
    ng2a[0] = 1'b0;
  endtask

  task automatic test_zero_dead_and_async_reset();
    bus_b.req_valid = 1'b1;
    bus_b.req_sel   = 4'd0;
    tick();
    bus_b.req_valid = 1'b0;
    n_chk += 7;
    if (bus_b.y !== 16'hFFFE) begin
      n_fail++; $display("FAIL zdead_y0: got %h, expected fffe", bus_b.y);
    end
    repeat (3) tick();
    bus_b.req_valid = 1'b1;
    bus_b.req_sel   = 4'd15;
    tick();
    bus_b.req_valid = 1'b0;
    if (bus_b.y !== 16'h7FFF) begin
      n_fail++; $display("FAIL zdead_y15: got %h, expected 7fff", bus_b.y);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    if (bus_b.y !== 16'hFFFF) begin
      n_fail++; $display("FAIL async_rst_y: got %h, expected ffff", bus_b.y);
    end
    if (bus_b.active !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_active: got %b, expected 0", bus_b.active);
    end
    if (bus_b.cur_sel !== 4'd0) begin
      n_fail++; $display("FAIL async_rst_cur_sel: got %0d, expected 0", bus_b.cur_sel);
    end
    @(negedge clk);
    rst_n = 1'b1;
    if (bus_b.y !== 16'hFFFF) begin
      n_fail++; $display("FAIL post_rst_y: got %h, expected ffff", bus_b.y);
    end
    bus_b.req_valid = 1'b1;
    bus_b.req_sel   = 4'd9;
    tick();
    bus_b.req_valid = 1'b0;
    if (bus_b.y !== 16'hFDFF) begin
      n_fail++; $display("FAIL post_rst_accept_y: got %h, expected fdff", bus_b.y);
    end
  endtask

`ifdef SYNC_CS_DECODER_MIN_ACTIVE_EN
  task automatic test_hold();
    logic [2:0] exp_rdy;
    apply_reset();
    bus_b.req_valid = 1'b1;
    bus_b.req_sel   = 4'd2;
    tick();
    bus_b.req_sel = 4'd3;
    exp_rdy = 3'b100;
    for (int k = 0; k < 3; k++) begin
      n_chk += 2;
      if (bus_b.req_ready !== exp_rdy[k]) begin
        n_fail++;
        $display("FAIL hold_ready cycle %0d: got %b, expected %b", k, bus_b.req_ready, exp_rdy[k]);
      end
      if (bus_b.y !== 16'hFFFB) begin
        n_fail++; $display("FAIL hold_y cycle %0d: got %h, expected fffb", k, bus_b.y);
      end
      tick();
    end
    bus_b.req_valid = 1'b0;
    n_chk += 2;
    if (bus_b.y !== 16'hFFF7) begin
      n_fail++; $display("FAIL hold_retarget_y: got %h, expected fff7", bus_b.y);
    end
    g1[1] = 1'b0;
    tick();
    g1[1] = 1'b1;
    if (bus_b.y !== 16'hFFFF) begin
      n_fail++; $display("FAIL hold_g1_drop_y: got %h, expected ffff", bus_b.y);
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] got_y   [2];
    logic        got_act [2];
    logic        got_rdy [2];
    int unsigned got_cs  [2];
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        g1[i]   = ($urandom_range(0, 15) != 0);
        ng2a[i] = ($urandom_range(0, 19) == 0);
        ng2b[i] = ($urandom_range(0, 19) == 0);
      end
      bus_a.req_valid = 1'($urandom_range(0, 1));
      bus_b.req_valid = 1'($urandom_range(0, 1));
      bus_a.req_sel = ($urandom_range(0, 3) == 0) ? 3'(m_sel[0]) : 3'($urandom);
      bus_b.req_sel = ($urandom_range(0, 3) == 0) ? 4'(m_sel[1]) : 4'($urandom);
      tick();
      got_y[0]   = {8'hFF, bus_a.y};
      got_y[1]   = bus_b.y;
      got_act[0] = bus_a.active;
      got_act[1] = bus_b.active;
      got_rdy[0] = bus_a.req_ready;
      got_rdy[1] = bus_b.req_ready;
      got_cs[0]  = int'(bus_a.cur_sel);
      got_cs[1]  = int'(bus_b.cur_sel);
      for (int i = 0; i < 2; i++) begin
        n_chk += 4;
        if (got_y[i] !== m_y(i)) begin
          n_fail++; $display("FAIL rand_y[%0d] k=%0d: got %h, expected %h", i, k, got_y[i], m_y(i));
        end
        if (got_act[i] !== m_live(i)) begin
          n_fail++;
          $display("FAIL rand_active[%0d] k=%0d: got %b, expected %b", i, k, got_act[i], m_live(i));
        end
        if (got_rdy[i] !== m_ready(i)) begin
          n_fail++;
          $display("FAIL rand_ready[%0d] k=%0d: got %b, expected %b", i, k, got_rdy[i], m_ready(i));
        end
        if (got_cs[i] != m_sel[i]) begin
          n_fail++;
          $display("FAIL rand_cur_sel[%0d] k=%0d: got %0d, expected %0d", i, k, got_cs[i], m_sel[i]);
        end
      end
    end
    bus_a.req_valid = 1'b0;
    bus_b.req_valid = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    g1              = 2'b11;
    ng2a            = 2'b00;
    ng2b            = 2'b00;
    bus_a.req_valid = 1'b0;
    bus_a.req_sel   = '0;
    bus_b.req_valid = 1'b0;
    bus_b.req_sel   = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_retarget();
    test_en_drop_dead();
    test_zero_dead_and_async_reset();
`ifdef SYNC_CS_DECODER_MIN_ACTIVE_EN
    test_hold();
`endif
    g1   = 2'b11;
    ng2a = 2'b00;
    ng2b = 2'b00;
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
